// File: rtl/d_pr_ps_reg_pkg.sv
// Shared constants for the d_pr_ps_reg family: default width and forced values.
// Optional feature macro: PR_PS_SYNC_EN (synchronous preset/clear).
`timescale 1ns/100ps

package d_pr_ps_reg_pkg;

    localparam int D_PR_PS_WIDTH = 1;

    // Per-bit forced values; every bit of the register shares them.
    localparam logic RESET_VALUE  = 1'b0;
    localparam logic PRESET_VALUE = 1'b1;

endpackage

// File: rtl/d_pr_ps_cell.sv
// Single-bit D flop with preset/clear and async active-low reset.
// With PR_PS_SYNC_EN defined, pr/ps are sampled on clk; rst_n stays async.
`timescale 1ns/100ps

module d_pr_ps_cell
    import d_pr_ps_reg_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    input  logic i_pr,
    input  logic i_ps,
    output logic o_q
);

    logic r_q;

`ifdef PR_PS_SYNC_EN

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= RESET_VALUE;
        else if (i_ps) r_q <= RESET_VALUE;
        else if (i_pr) r_q <= PRESET_VALUE;
        else           r_q <= i_d;
    end

`else

    logic w_clr_n;
    logic w_set;

    // Priority is resolved before the async pins, so releasing clear while
    // preset is still high produces a fresh set edge.
    assign w_clr_n = i_rst_n & ~i_ps;
    assign w_set   = w_clr_n & i_pr;

    always_ff @(posedge i_clk or negedge w_clr_n or posedge w_set) begin
        if (!w_clr_n)   r_q <= RESET_VALUE;
        else if (w_set) r_q <= PRESET_VALUE;
        else            r_q <= i_d;
    end

`endif

    assign o_q = r_q;

endmodule

// File: rtl/d_pr_ps_reg.sv
// WIDTH-bit register with shared preset (pr), clear (ps) and async reset.
// Optional feature macro: PR_PS_SYNC_EN (pr/ps sampled on clk instead of async).
`timescale 1ns/100ps

module d_pr_ps_reg
    import d_pr_ps_reg_pkg::*;
#(
    parameter int WIDTH = D_PR_PS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             pr,
    input  logic             ps,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            d_pr_ps_cell u_cell (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_d     (d[gi]),
                .i_pr    (pr),
                .i_ps    (ps),
                .o_q     (q[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_d_pr_ps_reg.sv
// Directed bench for d_pr_ps_reg: sampled model checked every time unit plus literal checkpoints.
// Honours PR_PS_SYNC_EN for both the model and the literal expectations.
`timescale 1ns/100ps

module tb_d_pr_ps_reg;

    localparam int W = 4;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] d     = '0;
    logic         pr    = 1'b0;
    logic         ps    = 1'b0;
    logic [W-1:0] q;

    int n_assert = 0;
    int n_fail   = 0;
    int edges    = 0;
    bit done     = 1'b0;

    d_pr_ps_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .pr    (pr),
        .ps    (ps),
        .q     (q)
    );

    // Rising edges at 5, 15, 25, ...; no input ever changes on an edge.
    initial forever #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0.1f: q=%h expected %h", name, $realtime, act, exp);
        end
    endtask

    task automatic at(input real t);
        if ($realtime < t) #(t - $realtime);
    endtask

    // Literal checkpoint sampled half a unit after time t.
    task automatic lit(input real t, input string name,
                       input logic [W-1:0] e_async, input logic [W-1:0] e_sync);
        at(t + 0.5);
`ifdef PR_PS_SYNC_EN
        check(name, q, e_sync);
`else
        check(name, q, e_async);
`endif
    endtask

    // Sampled model: inputs only change at integer times, so the values seen
    // at the previous half-unit sample are the values present at any edge in between.
    initial begin : model
        int           last_edges;
        logic         p_rst, p_pr, p_ps;
        logic [W-1:0] p_d, held;
        last_edges = 0;
        p_rst = 1'b0; p_pr = 1'b0; p_ps = 1'b0; p_d = '0; held = '0;
        #0.5;
        while (!done) begin
            if (edges != last_edges) begin
                last_edges = edges;
`ifdef PR_PS_SYNC_EN
                if (!p_rst || p_ps) held = '0;
                else if (p_pr)      held = ONES;
                else                held = p_d;
`else
                if (p_rst && !p_ps && !p_pr) held = p_d;
`endif
            end
            if (!rst_n) held = '0;
`ifndef PR_PS_SYNC_EN
            else if (ps) held = '0;
            else if (pr) held = ONES;
`endif
            check("model", q, held);
            p_rst = rst_n; p_pr = pr; p_ps = ps; p_d = d;
            #1;
        end
    end

    initial begin : stim
        rst_n = 1'b0; d = ONES; pr = 1'b1;
        lit(0,   "rst_async",   4'h0, 4'h0);
        at(2);   pr = 1'b0;
        lit(26,  "rst_hold",    4'h0, 4'h0);
        at(27);  rst_n = 1'b1;
        lit(27,  "rst_release", 4'h0, 4'h0);
        lit(36,  "first_cap",   4'hF, 4'hF);
        // Capture with d toggling between edges.
        at(37);  d = 4'h3;
        at(40);  d = 4'hA;
        at(43);  d = 4'h5;
        lit(46,  "cap0",        4'h5, 4'h5);
        at(48);  d = 4'hC;
        at(51);  d = 4'h6;
        at(54);  d = 4'h9;
        lit(56,  "cap1",        4'h9, 4'h9);
        at(58);  d = 4'h0;
        at(66);  d = 4'h7;
        // Preset pulse with no edge inside.
        at(67);  pr = 1'b1;
        lit(67,  "pr_pulse_on", 4'hF, 4'h0);
        at(68);  pr = 1'b0;
        lit(70,  "pr_pulse_hold", 4'hF, 4'h0);
        lit(76,  "pr_pulse_follow", 4'h7, 4'h7);
        at(77);  d = ONES;
        // Clear pulse with no edge inside.
        at(87);  ps = 1'b1;
        lit(87,  "ps_pulse_on", 4'h0, 4'hF);
        at(88);  ps = 1'b0; d = 4'hA;
        lit(90,  "ps_pulse_hold", 4'h0, 4'hF);
        lit(96,  "ps_pulse_follow", 4'hA, 4'hA);
        // Both controls: clear dominates, then preset takes over.
        at(97);  pr = 1'b1; ps = 1'b1;
        lit(97,  "both_high",   4'h0, 4'hA);
        at(99);  ps = 1'b0;
        lit(99,  "ps_drop",     4'hF, 4'hA);
        lit(106, "pr_at_edge",  4'hF, 4'hF);
        at(107); pr = 1'b0; d = 4'h3;
        lit(116, "after_force", 4'h3, 4'h3);
        at(117); d = 4'h0;
        // Preset pulse spanning the edge at 135 with d=0.
        at(134); pr = 1'b1;
        lit(134, "span_pre",    4'hF, 4'h0);
        at(136); pr = 1'b0;
        lit(136, "span_post",   4'hF, 4'hF);
        lit(146, "span_follow", 4'h0, 4'h0);
        // Clear pulse spanning the edge at 155 with d all ones.
        at(147); d = ONES;
        at(153); ps = 1'b1;
        at(156); ps = 1'b0;
        lit(156, "ps_span",     4'h0, 4'h0);
        lit(166, "ps_span_follow", 4'hF, 4'hF);
        // Reset in mid-operation.
        at(167); rst_n = 1'b0;
        lit(167, "rst_mid",     4'h0, 4'h0);
        at(169); rst_n = 1'b1; d = 4'h6;
        lit(176, "rst_recover", 4'h6, 4'h6);
        at(180); done = 1'b1;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
